multicycle_ctrl: RTL and testbench
==================================

Name: multicycle_ctrl

Overview:
Main control FSM for the multicycle RV32I subset core (lw, sw, R-type, I-type ALU, beq, jal).
- Sequences the shared datapath (one ALU, one unified instruction/data memory, PC, IR, ALUOut and Data registers) through Fetch/Decode/Execute/Memory/Writeback steps.
- Drives mux selects, register write enables and the ALUOp field consumed by the ALU decoder.
- Waits on a memory-ready handshake.

Parameters:
none

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high; forces FSM to Fetch
op  input  7  opcode from IR[6:0]
Zero  input  1  ALU zero flag
MemReady  input  1  memory access complete this cycle
PCWrite  output  1  PC register enable = (Branch & Zero) | PCUpdate
AdrSrc  output  1  memory address: 0 PC, 1 Result
MemWrite  output  1  memory write strobe
IRWrite  output  1  IR/OldPC capture enable
ResultSrc  output  2  00 ALUOut, 01 Data, 10 ALUResult
ALUSrcA  output  2  00 PC, 01 OldPC, 10 RD1
ALUSrcB  output  2  00 WriteData(RD2), 01 ImmExt, 10 constant 4
ALUOp  output  2  00 add, 01 subtract/compare, 10 funct-decoded
ImmSrc  output  2  00 I, 01 S, 10 B, 11 J
RegWrite  output  1  register file write enable
IllegalOp  output  1  one-cycle pulse in Decode on unsupported opcode
State  output  4  current state encoding, for debug

Behaviour:
- State register updates on posedge clk; all outputs are combinational (Moore, except handshake gating).
- State encoding: Fetch=0, Decode=1, MemAdr=2, MemRead=3, MemWB=4, MemWrite=5, ExecuteR=6, ALUWB=7, ExecuteI=8, JAL=9, BEQ=10. Codes 11-15 -> next state Fetch, all enables 0.
- Reset: State=0 immediately. While reset is high, PCWrite/IRWrite/MemWrite/RegWrite/IllegalOp=0; selects take Fetch values.
- Every output not listed for a state is 0.
- Fetch: AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10. IRWrite=1 and PCUpdate=1 only when MemReady=1. Holds in Fetch until MemReady=1, then -> Decode.
- Decode: ALUSrcA=01, ALUSrcB=01, ALUOp=00 (branch/jump target into ALUOut). Next state by op:
  - 0000011 or 0100011 -> MemAdr
  - 0110011 -> ExecuteR
  - 0010011 -> ExecuteI
  - 1101111 -> JAL
  - 1100011 -> BEQ
  - other -> Fetch with IllegalOp=1
- MemAdr: ALUSrcA=10, ALUSrcB=01, ALUOp=00. op=0000011 -> MemRead, else -> MemWrite.
- MemRead: AdrSrc=1, ResultSrc=00. Holds until MemReady=1, then -> MemWB.
- MemWB: ResultSrc=01, RegWrite=1, -> Fetch.
- MemWrite: AdrSrc=1, ResultSrc=00, MemWrite=1 while in state. Holds until MemReady=1, then -> Fetch.
- ExecuteR: ALUSrcA=10, ALUSrcB=00, ALUOp=10, -> ALUWB.
- ExecuteI: ALUSrcA=10, ALUSrcB=01, ALUOp=10, -> ALUWB.
- ALUWB: ResultSrc=00, RegWrite=1, -> Fetch.
- JAL: ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCUpdate=1, -> ALUWB.
- BEQ: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, Branch=1, -> Fetch. PCWrite = Zero.
- ImmSrc is decoded combinationally from op in every state: lw/I-type 00, sw 01, beq 10, jal 11, other 00.
- Latency with MemReady tied to 1: beq 3 cycles; R, I, sw, jal 4 cycles; lw 5 cycles. Each low-MemReady cycle in Fetch, MemRead or MemWrite adds one cycle.
- Reset asserted mid-instruction: abandon it, return to Fetch, no partial write.

Test Plan:
- Reset high 3 cycles, then release with MemReady=1 -> State 0 during reset, all enables 0; first posedge after release -> State=1; IRWrite=1, PCWrite=1 in the Fetch cycle.
- op=0110011, MemReady=1 -> states 0,1,6,7,0. ALUOp=10 in state 6. RegWrite=1 only in state 7.
- op=0000011 with MemReady low 2 cycles in MemRead -> states 0,1,2,3,3,3,4,0. RegWrite=1 only in state 4. AdrSrc=1 in state 3.
- op=1100011: Zero=1 -> PCWrite=1 in BEQ. Zero=0 -> PCWrite=0. Both cases: ImmSrc=10, return to Fetch after 3 cycles.
- op=1101111 -> states 0,1,9,7,0. PCWrite=1 in state 9. ImmSrc=11. RegWrite=1 in state 7.
- op=1110011 (unsupported) -> IllegalOp=1 in Decode, next state 0, no RegWrite/MemWrite. Additionally, assert reset during MemWrite -> MemWrite drops immediately, State=0.

Source files
------------

// File: rtl/multicycle_ctrl_if.sv
// Control bundle between the multicycle controller and the shared datapath.
// The controller takes the slave side; the datapath (or bench) drives the master side.
interface multicycle_ctrl_if;
    logic [6:0] op;
    logic       Zero;
    logic       MemReady;
    logic       PCWrite;
    logic       AdrSrc;
    logic       MemWrite;
    logic       IRWrite;
    logic [1:0] ResultSrc;
    logic [1:0] ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] ALUOp;
    logic [1:0] ImmSrc;
    logic       RegWrite;
    logic       IllegalOp;
    logic [3:0] State;

    modport slave (
        input  op, Zero, MemReady,
        output PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
               ALUOp, ImmSrc, RegWrite, IllegalOp, State
    );

    modport master (
        output op, Zero, MemReady,
        input  PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
               ALUOp, ImmSrc, RegWrite, IllegalOp, State
    );
endinterface

// File: rtl/multicycle_ctrl.sv
// Main control FSM for the multicycle RV32I-subset core (lw, sw, R, I-ALU, beq, jal).
// Moore outputs decoded from the state register; write enables are forced low during reset.
module multicycle_ctrl (
    input  logic             clk,
    input  logic             reset,
    multicycle_ctrl_if.slave bus
);

    typedef enum logic [3:0] {
        ST_FETCH    = 4'd0,
        ST_DECODE   = 4'd1,
        ST_MEMADR   = 4'd2,
        ST_MEMREAD  = 4'd3,
        ST_MEMWB    = 4'd4,
        ST_MEMWRITE = 4'd5,
        ST_EXECR    = 4'd6,
        ST_ALUWB    = 4'd7,
        ST_EXECI    = 4'd8,
        ST_JAL      = 4'd9,
        ST_BEQ      = 4'd10
    } state_t;

    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_BEQ  = 7'b1100011;

    state_t     state_r;
    logic       pcupdate_s;
    logic       branch_s;
    logic       adrsrc_s;
    logic       memwrite_s;
    logic       irwrite_s;
    logic       regwrite_s;
    logic       illegal_s;
    logic [1:0] resultsrc_s;
    logic [1:0] alusrca_s;
    logic [1:0] alusrcb_s;
    logic [1:0] aluop_s;
    logic [1:0] immsrc_s;

    function automatic logic op_supported(input logic [6:0] o);
        case (o)
            OP_LW, OP_SW, OP_R, OP_I, OP_JAL, OP_BEQ: op_supported = 1'b1;
            default:                                 op_supported = 1'b0;
        endcase
    endfunction

    // State register and next-state sequencing
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= ST_FETCH;
        end else begin
            case (state_r)
                ST_FETCH:    state_r <= bus.MemReady ? ST_DECODE : ST_FETCH;
                ST_DECODE: begin
                    case (bus.op)
                        OP_LW, OP_SW: state_r <= ST_MEMADR;
                        OP_R:         state_r <= ST_EXECR;
                        OP_I:         state_r <= ST_EXECI;
                        OP_JAL:       state_r <= ST_JAL;
                        OP_BEQ:       state_r <= ST_BEQ;
                        default:      state_r <= ST_FETCH;
                    endcase
                end
                ST_MEMADR:   state_r <= (bus.op == OP_LW) ? ST_MEMREAD : ST_MEMWRITE;
                ST_MEMREAD:  state_r <= bus.MemReady ? ST_MEMWB : ST_MEMREAD;
                ST_MEMWB:    state_r <= ST_FETCH;
                ST_MEMWRITE: state_r <= bus.MemReady ? ST_FETCH : ST_MEMWRITE;
                ST_EXECR:    state_r <= ST_ALUWB;
                ST_EXECI:    state_r <= ST_ALUWB;
                ST_ALUWB:    state_r <= ST_FETCH;
                ST_JAL:      state_r <= ST_ALUWB;
                ST_BEQ:      state_r <= ST_FETCH;
                default:     state_r <= ST_FETCH;
            endcase
        end
    end

    // Per-state datapath selects and raw enables
    always_comb begin
        pcupdate_s  = 1'b0;
        branch_s    = 1'b0;
        adrsrc_s    = 1'b0;
        memwrite_s  = 1'b0;
        irwrite_s   = 1'b0;
        regwrite_s  = 1'b0;
        illegal_s   = 1'b0;
        resultsrc_s = 2'b00;
        alusrca_s   = 2'b00;
        alusrcb_s   = 2'b00;
        aluop_s     = 2'b00;
        case (state_r)
            ST_FETCH: begin
                alusrcb_s   = 2'b10;
                resultsrc_s = 2'b10;
                irwrite_s   = bus.MemReady;
                pcupdate_s  = bus.MemReady;
            end
            ST_DECODE: begin
                alusrca_s = 2'b01;
                alusrcb_s = 2'b01;
                illegal_s = ~op_supported(bus.op);
            end
            ST_MEMADR: begin
                alusrca_s = 2'b10;
                alusrcb_s = 2'b01;
            end
            ST_MEMREAD: begin
                adrsrc_s = 1'b1;
            end
            ST_MEMWB: begin
                resultsrc_s = 2'b01;
                regwrite_s  = 1'b1;
            end
            ST_MEMWRITE: begin
                adrsrc_s   = 1'b1;
                memwrite_s = 1'b1;
            end
            ST_EXECR: begin
                alusrca_s = 2'b10;
                aluop_s   = 2'b10;
            end
            ST_EXECI: begin
                alusrca_s = 2'b10;
                alusrcb_s = 2'b01;
                aluop_s   = 2'b10;
            end
            ST_ALUWB: begin
                regwrite_s = 1'b1;
            end
            ST_JAL: begin
                alusrca_s  = 2'b01;
                alusrcb_s  = 2'b10;
                pcupdate_s = 1'b1;
            end
            ST_BEQ: begin
                alusrca_s = 2'b10;
                aluop_s   = 2'b01;
                branch_s  = 1'b1;
            end
            default: begin
                pcupdate_s = 1'b0;
            end
        endcase
    end

    // Immediate format follows the opcode in every state
    always_comb begin
        case (bus.op)
            OP_SW:   immsrc_s = 2'b01;
            OP_BEQ:  immsrc_s = 2'b10;
            OP_JAL:  immsrc_s = 2'b11;
            default: immsrc_s = 2'b00;
        endcase
    end

    // Reset must not let a stale MemReady/Zero open any write path
    assign bus.PCWrite   = ((branch_s & bus.Zero) | pcupdate_s) & ~reset;
    assign bus.IRWrite   = irwrite_s & ~reset;
    assign bus.MemWrite  = memwrite_s & ~reset;
    assign bus.RegWrite  = regwrite_s & ~reset;
    assign bus.IllegalOp = illegal_s & ~reset;
    assign bus.AdrSrc    = adrsrc_s;
    assign bus.ResultSrc = resultsrc_s;
    assign bus.ALUSrcA   = alusrca_s;
    assign bus.ALUSrcB   = alusrcb_s;
    assign bus.ALUOp     = aluop_s;
    assign bus.ImmSrc    = immsrc_s;
    assign bus.State     = state_r;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed table-driven bench for multicycle_ctrl plus latency and reset corner sequences.
module tb_multicycle_ctrl;

    localparam logic [6:0] R   = 7'b0110011;
    localparam logic [6:0] LW  = 7'b0000011;
    localparam logic [6:0] SW  = 7'b0100011;
    localparam logic [6:0] IT  = 7'b0010011;
    localparam logic [6:0] BQ  = 7'b1100011;
    localparam logic [6:0] JL  = 7'b1101111;
    localparam logic [6:0] BAD = 7'b1110011;

    typedef struct packed {
        logic        rst;
        logic [6:0]  op;
        logic        zero;
        logic        mr;
        logic [19:0] exp;
    } vec_t;

    logic clk;
    logic reset;
    int   total;
    int   bad;
    vec_t vecs[$];

    multicycle_ctrl_if bus ();

    multicycle_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // {State, PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB, ALUOp, ImmSrc, RegWrite, IllegalOp}
    function automatic logic [19:0] mk(input logic [3:0] st, input logic pcw, input logic adr,
                                       input logic mw, input logic irw, input logic [1:0] rs,
                                       input logic [1:0] sa, input logic [1:0] sb,
                                       input logic [1:0] aop, input logic [1:0] imm,
                                       input logic rw, input logic ill);
        mk = {st, pcw, adr, mw, irw, rs, sa, sb, aop, imm, rw, ill};
    endfunction

    function automatic logic [19:0] actual();
        actual = {bus.State, bus.PCWrite, bus.AdrSrc, bus.MemWrite, bus.IRWrite, bus.ResultSrc,
                  bus.ALUSrcA, bus.ALUSrcB, bus.ALUOp, bus.ImmSrc, bus.RegWrite, bus.IllegalOp};
    endfunction

    task automatic add(input logic r, input logic [6:0] o, input logic z, input logic m,
                       input logic [19:0] e);
        vec_t v;
        v.rst = r;
        v.op = o;
        v.zero = z;
        v.mr = m;
        v.exp = e;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [19:0] act, input logic [19:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %05h expected %05h", name, act, exp);
        end
    endtask

    // Reset into Fetch, then count posedges until State returns to Fetch
    task automatic measure(input string name, input logic [6:0] o, input int exp_cycles);
        int cycles;
        @(negedge clk);
        bus.op = o;
        bus.MemReady = 1'b1;
        bus.Zero = 1'b0;
        reset = 1'b1;
        #1;
        reset = 1'b0;
        cycles = 0;
        do begin
            @(posedge clk);
            #1;
            cycles++;
        end while (bus.State != 4'd0 && cycles < 20);
        total++;
        if (cycles != exp_cycles) begin
            bad++;
            $display("FAIL %s: got %0d cycles expected %0d", name, cycles, exp_cycles);
        end
    endtask

    initial begin
        reset = 1'b1;
        bus.op = R;
        bus.Zero = 1'b0;
        bus.MemReady = 1'b1;
        total = 0;
        bad = 0;

        // reset held: Fetch selects, enables off
        for (int i = 0; i < 3; i++)
            add(1'b1, R, 1'b0, 1'b1, mk(4'd0,1'b0,1'b0,1'b0,1'b0,2'b10,2'b00,2'b10,2'b00,2'b00,1'b0,1'b0));
        // R-type
        add(1'b0, R, 1'b0, 1'b1, mk(4'd0,1'b1,1'b0,1'b0,1'b1,2'b10,2'b00,2'b10,2'b00,2'b00,1'b0,1'b0));
        add(1'b0, R, 1'b0, 1'b1, mk(4'd1,1'b0,1'b0,1'b0,1'b0,2'b00,2'b01,2'b01,2'b00,2'b00,1'b0,1'b0));
        add(1'b0, R, 1'b0, 1'b1, mk(4'd6,1'b0,1'b0,1'b0,1'b0,2'b00,2'b10,2'b00,2'b10,2'b00,1'b0,1'b0));
        add(1'b0, R, 1'b0, 1'b1, mk(4'd7,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,2'b00,2'b00,2'b00,1'b1,1'b0));
        // lw with one Fetch stall and two MemRead stalls
        add(1'b0, LW, 1'b0, 1'b0, mk(4'd0,1'b0,1'b0,1'b0,1'b0,2'b10,2'b00,2'b10,2'b00,2'b00,1'b0,1'b0));
        add(1'b0, LW, 1'b0, 1'b1, mk(4'd0,1'b1,1'b0,1'b0,1'b1,2'b10,2'b00,2'b10,2'b00,2'b00,1'b0,1'b0));
        add(1'b0, LW, 1'b0, 1'b1, mk(4'd1,1'b0,1'b0,1'b0,1'b0,2'b00,2'b01,2'b01,2'b00,2'b00,1'b0,1'b0));
        add(1'b0, LW, 1'b0, 1'b1, mk(4'd2,1'b0,1'b0,1'b0,1'b0,2'b00,2'b10,2'b01,2'b00,2'b00,1'b0,1'b0));
        add(1'b0, LW, 1'b0, 1'b0, mk(4'd3,1'b0,1'b1,1'b0,1'b0,2'b00,2'b00,2'b00,2'b00,2'b00,1'b0,1'b0));
        add(1'b0, LW, 1'b0, 1'b0, mk(4'd3,1'b0,1'b1,1'b0,1'b0,2'b00,2'b00,2'b00,2'b00,2'b00,1'b0,1'b0));
        add(1'b0, LW, 1'b0, 1'b1, mk(4'd3,1'b0,1'b1,1'b0,1'b0,2'b00,2'b00,2'b00,2'b00,2'b00,1'b0,1'b0));
        add(1'b0, LW, 1'b0, 1'b1, mk(4'd4,1'b0,1'b0,1'b0,1'b0,2'b01,2'b00,2'b00,2'b00,2'b00,1'b1,1'b0));
        // beq taken
        add(1'b0, BQ, 1'b1, 1'b1, mk(4'd0,1'b1,1'b0,1'b0,1'b1,2'b10,2'b00,2'b10,2'b00,2'b10,1'b0,1'b0));
        add(1'b0, BQ, 1'b1, 1'b1, mk(4'd1,1'b0,1'b0,1'b0,1'b0,2'b00,2'b01,2'b01,2'b00,2'b10,1'b0,1'b0));
        add(1'b0, BQ, 1'b1, 1'b1, mk(4'd10,1'b1,1'b0,1'b0,1'b0,2'b00,2'b10,2'b00,2'b01,2'b10,1'b0,1'b0));
        // beq not taken (Zero high outside BEQ must not leak into PCWrite in Decode)
        add(1'b0, BQ, 1'b1, 1'b1, mk(4'd0,1'b1,1'b0,1'b0,1'b1,2'b10,2'b00,2'b10,2'b00,2'b10,1'b0,1'b0));
        add(1'b0, BQ, 1'b1, 1'b1, mk(4'd1,1'b0,1'b0,1'b0,1'b0,2'b00,2'b01,2'b01,2'b00,2'b10,1'b0,1'b0));
        add(1'b0, BQ, 1'b0, 1'b1, mk(4'd10,1'b0,1'b0,1'b0,1'b0,2'b00,2'b10,2'b00,2'b01,2'b10,1'b0,1'b0));
        // jal
        add(1'b0, JL, 1'b0, 1'b1, mk(4'd0,1'b1,1'b0,1'b0,1'b1,2'b10,2'b00,2'b10,2'b00,2'b11,1'b0,1'b0));
        add(1'b0, JL, 1'b0, 1'b1, mk(4'd1,1'b0,1'b0,1'b0,1'b0,2'b00,2'b01,2'b01,2'b00,2'b11,1'b0,1'b0));
        add(1'b0, JL, 1'b0, 1'b1, mk(4'd9,1'b1,1'b0,1'b0,1'b0,2'b00,2'b01,2'b10,2'b00,2'b11,1'b0,1'b0));
        add(1'b0, JL, 1'b0, 1'b1, mk(4'd7,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,2'b00,2'b00,2'b11,1'b1,1'b0));
        // I-type ALU
        add(1'b0, IT, 1'b0, 1'b1, mk(4'd0,1'b1,1'b0,1'b0,1'b1,2'b10,2'b00,2'b10,2'b00,2'b00,1'b0,1'b0));
        add(1'b0, IT, 1'b0, 1'b1, mk(4'd1,1'b0,1'b0,1'b0,1'b0,2'b00,2'b01,2'b01,2'b00,2'b00,1'b0,1'b0));
        add(1'b0, IT, 1'b0, 1'b1, mk(4'd8,1'b0,1'b0,1'b0,1'b0,2'b00,2'b10,2'b01,2'b10,2'b00,1'b0,1'b0));
        add(1'b0, IT, 1'b0, 1'b1, mk(4'd7,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,2'b00,2'b00,2'b00,1'b1,1'b0));
        // unsupported opcode
        add(1'b0, BAD, 1'b0, 1'b1, mk(4'd0,1'b1,1'b0,1'b0,1'b1,2'b10,2'b00,2'b10,2'b00,2'b00,1'b0,1'b0));
        add(1'b0, BAD, 1'b0, 1'b1, mk(4'd1,1'b0,1'b0,1'b0,1'b0,2'b00,2'b01,2'b01,2'b00,2'b00,1'b0,1'b1));
        // sw, reset in MemWrite abandons the store
        add(1'b0, SW, 1'b0, 1'b1, mk(4'd0,1'b1,1'b0,1'b0,1'b1,2'b10,2'b00,2'b10,2'b00,2'b01,1'b0,1'b0));
        add(1'b0, SW, 1'b0, 1'b1, mk(4'd1,1'b0,1'b0,1'b0,1'b0,2'b00,2'b01,2'b01,2'b00,2'b01,1'b0,1'b0));
        add(1'b0, SW, 1'b0, 1'b1, mk(4'd2,1'b0,1'b0,1'b0,1'b0,2'b00,2'b10,2'b01,2'b00,2'b01,1'b0,1'b0));
        add(1'b0, SW, 1'b0, 1'b0, mk(4'd5,1'b0,1'b1,1'b1,1'b0,2'b00,2'b00,2'b00,2'b00,2'b01,1'b0,1'b0));
        add(1'b1, SW, 1'b0, 1'b1, mk(4'd0,1'b0,1'b0,1'b0,1'b0,2'b10,2'b00,2'b10,2'b00,2'b01,1'b0,1'b0));
        // sw completing normally
        add(1'b0, SW, 1'b0, 1'b1, mk(4'd0,1'b1,1'b0,1'b0,1'b1,2'b10,2'b00,2'b10,2'b00,2'b01,1'b0,1'b0));
        add(1'b0, SW, 1'b0, 1'b1, mk(4'd1,1'b0,1'b0,1'b0,1'b0,2'b00,2'b01,2'b01,2'b00,2'b01,1'b0,1'b0));
        add(1'b0, SW, 1'b0, 1'b1, mk(4'd2,1'b0,1'b0,1'b0,1'b0,2'b00,2'b10,2'b01,2'b00,2'b01,1'b0,1'b0));
        add(1'b0, SW, 1'b0, 1'b1, mk(4'd5,1'b0,1'b1,1'b1,1'b0,2'b00,2'b00,2'b00,2'b00,2'b01,1'b0,1'b0));
        add(1'b0, SW, 1'b0, 1'b1, mk(4'd0,1'b1,1'b0,1'b0,1'b1,2'b10,2'b00,2'b10,2'b00,2'b01,1'b0,1'b0));

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            reset = vecs[i].rst;
            bus.op = vecs[i].op;
            bus.Zero = vecs[i].zero;
            bus.MemReady = vecs[i].mr;
            #1;
            check($sformatf("vec%0d", i), actual(), vecs[i].exp);
        end

        measure("lat_lw", LW, 5);
        measure("lat_beq", BQ, 3);
        measure("lat_r", R, 4);
        measure("lat_i", IT, 4);
        measure("lat_sw", SW, 4);
        measure("lat_jal", JL, 4);
        measure("lat_bad", BAD, 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
